// File: rtl/overlay_pkg.sv
// Shared constants and state encoding for the game-over overlay plotter.
// The plotter walks a snapshot of the overlay bitmap and emits one VGA pixel per clock.
package overlay_pkg;

  localparam int OVL_WIDTH  = 100;
  localparam int OVL_HEIGHT = 23;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    FINISH
  } ovl_state_e;

endpackage

// File: rtl/overlay_scan_counter.sv
// Column/row raster counter with clear, enable and wrap.
// The last flag marks the final pixel of the bitmap.
module overlay_scan_counter
  import overlay_pkg::*;
#(
  parameter int WIDTH  = OVL_WIDTH,
  parameter int HEIGHT = OVL_HEIGHT,
  parameter int CW     = $clog2(WIDTH),
  parameter int RW     = $clog2(HEIGHT)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic col_end, row_end;

  assign col_end = (col == CW'(WIDTH - 1));
  assign row_end = (row == RW'(HEIGHT - 1));
  assign last    = col_end && row_end;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/overlay_plotter.sv
// Draws a snapshot of the overlay bitmap into the VGA adapter frame buffer,
// one registered pixel per clock, with pause and a one-cycle done pulse.
module overlay_plotter
  import overlay_pkg::*;
#(
  parameter int         WIDTH       = OVL_WIDTH,
  parameter int         HEIGHT      = OVL_HEIGHT,
  parameter int         X_ORIGIN    = 30,
  parameter int         Y_ORIGIN    = 48,
  parameter logic [2:0] FG_COLOUR   = COL_WHITE,
  parameter logic [2:0] BG_COLOUR   = COL_BLACK,
  parameter bit         TRANSPARENT = 1'b0
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      pause,
  input  logic [WIDTH*HEIGHT-1:0]   bitmap,
  output logic [7:0]                x,
  output logic [6:0]                y,
  output logic [2:0]                colour,
  output logic                      plot,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int IW = $clog2(WIDTH * HEIGHT);

  if (X_ORIGIN + WIDTH > SCREEN_W || Y_ORIGIN + HEIGHT > SCREEN_H) begin : g_bad_origin
    $error("overlay_plotter: bitmap does not fit inside the 160x120 screen");
  end

  ovl_state_e              state;
  logic [WIDTH*HEIGHT-1:0] snap;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic [IW-1:0]           idx;
  logic                    clr, adv, last, pix;

  assign clr = (state == IDLE) && start;
  assign adv = (state == DRAW) && !pause;

  // MSB of each row word is the leftmost column.
  assign idx = IW'(row) * IW'(WIDTH) + IW'(WIDTH - 1) - IW'(col);
  assign pix = snap[idx];

  overlay_scan_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .CW    (CW),
    .RW    (RW)
  ) u_scan (
    .clock (clock),
    .resetn(resetn),
    .clear (clr),
    .en    (adv),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  // Snapshot isolates the draw from upstream text changes.
  always_ff @(posedge clock) begin
    if (clr) snap <= bitmap;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      colour <= BG_COLOUR;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= DRAW;
          end
        end
        DRAW: begin
          if (pause) begin
            plot <= 1'b0;
          end else begin
            x      <= 8'(X_ORIGIN) + 8'(col);
            y      <= 7'(Y_ORIGIN) + 7'(row);
            colour <= pix ? FG_COLOUR : BG_COLOUR;
            plot   <= TRANSPARENT ? pix : 1'b1;
            if (last) state <= FINISH;
          end
        end
        FINISH: begin
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
